// File: rtl/svm_ovo_scheduler_if.sv
// Scheduler bus: host request/result plus the shared binary-SVM / weight-ROM handshake.
// master = host + SVM side (drives requests and results), slave = the scheduler.
interface svm_ovo_scheduler_if #(
  parameter int unsigned N_CLASSES  = 4,
  parameter int unsigned inputWidth = 4,
  parameter int unsigned N_features = 21
);
  localparam int unsigned P      = N_CLASSES * (N_CLASSES - 1) / 2;
  localparam int unsigned CLS_W  = (N_CLASSES > 2) ? $clog2(N_CLASSES) : 1;
  localparam int unsigned PAIR_W = (P > 2) ? $clog2(P) : 1;
  localparam int unsigned FEAT_W = inputWidth * N_features;

  logic              start;
  logic [FEAT_W-1:0] feat_in;
  logic [FEAT_W-1:0] feat_out;
  logic [PAIR_W-1:0] pair_idx;
  logic              svm_start;
  logic              svm_ready;
  logic              svm_class;
  logic              busy;
  logic              done;
  logic [CLS_W-1:0]  winner;
  logic              error;

  modport master (
    output start, feat_in, svm_ready, svm_class,
    input  feat_out, pair_idx, svm_start, busy, done, winner, error
  );

  modport slave (
    input  start, feat_in, svm_ready, svm_class,
    output feat_out, pair_idx, svm_start, busy, done, winner, error
  );
endinterface

// File: rtl/svm_ovo_scheduler.sv
// One-vs-one scheduler: walks every class pair through one shared binary SVM, tallies votes, argmax.
// Optional WAIT watchdog enabled by defining SVM_SCHED_WATCHDOG_EN.
module svm_ovo_scheduler #(
  parameter int unsigned N_CLASSES  = 4,
  parameter int unsigned inputWidth = 4,
  parameter int unsigned N_features = 21,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic               clk,
  input logic               rst,
  svm_ovo_scheduler_if.slave bus
);
  localparam int unsigned P      = N_CLASSES * (N_CLASSES - 1) / 2;
  localparam int unsigned CLS_W  = (N_CLASSES > 2) ? $clog2(N_CLASSES) : 1;
  localparam int unsigned PAIR_W = (P > 2) ? $clog2(P) : 1;
  localparam int unsigned VOTE_W = $clog2(N_CLASSES);

  generate
    if (N_CLASSES < 2 || TIMEOUT == 0 || inputWidth * N_features == 0) begin : g_param_check
      $error("svm_ovo_scheduler: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    TALLY  = 3'd3,
    DECIDE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [CLS_W-1:0]   cls_a, cls_b, k, best;
  logic [VOTE_W-1:0]  votes [N_CLASSES];
  logic               cls_q;
  logic               accept, tally, advance;
  logic               last_pair, b_last, k_last, k_better;

`ifdef SVM_SCHED_WATCHDOG_EN
  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0]   wdog;
  logic               wait_abort;
`endif

  assign last_pair = (bus.pair_idx == PAIR_W'(P - 1));
  assign b_last    = (cls_b == CLS_W'(N_CLASSES - 1));
  assign k_last    = (k == CLS_W'(N_CLASSES - 1));
  assign k_better  = (votes[k] > votes[best]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    tally   = 1'b0;
    advance = 1'b0;
`ifdef SVM_SCHED_WATCHDOG_EN
    wait_abort = 1'b0;
`endif
    case (state)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_n = LAUNCH;
      end
      LAUNCH: state_n = WAIT;
      WAIT: begin
        if (bus.svm_ready) state_n = TALLY;
`ifdef SVM_SCHED_WATCHDOG_EN
        else if (wdog == TMO_W'(TIMEOUT - 1)) begin
          state_n    = DONE;
          wait_abort = 1'b1;
        end
`endif
      end
      TALLY: begin
        tally = 1'b1;
        if (last_pair) state_n = DECIDE;
        else begin
          advance = 1'b1;
          state_n = LAUNCH;
        end
      end
      DECIDE:  if (k_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes decoded from the next state keep outputs aligned with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.feat_out  <= '0;
      bus.pair_idx  <= '0;
      bus.svm_start <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.winner    <= '0;
      bus.error     <= 1'b0;
      cls_a         <= '0;
      cls_b         <= '0;
      k             <= '0;
      best          <= '0;
      cls_q         <= 1'b0;
      for (int unsigned i = 0; i < N_CLASSES; i++) votes[i] <= '0;
`ifdef SVM_SCHED_WATCHDOG_EN
      wdog          <= '0;
`endif
    end else begin
      bus.svm_start <= (state_n == LAUNCH);
      bus.busy      <= (state_n inside {LAUNCH, WAIT, TALLY, DECIDE});
      bus.done      <= (state_n == DONE);

      if (accept) begin
        bus.feat_out <= bus.feat_in;
        bus.pair_idx <= '0;
        bus.error    <= 1'b0;
        cls_a        <= '0;
        cls_b        <= CLS_W'(1);
        for (int unsigned i = 0; i < N_CLASSES; i++) votes[i] <= '0;
      end

      if (state == WAIT && bus.svm_ready) cls_q <= bus.svm_class;

      if (tally) begin
        if (cls_q) votes[cls_a] <= votes[cls_a] + VOTE_W'(1);
        else       votes[cls_b] <= votes[cls_b] + VOTE_W'(1);
        k    <= '0;
        best <= '0;
      end

      // Pair order (a,b): b runs a+1..N-1, then a steps and b restarts at a+1.
      if (advance) begin
        bus.pair_idx <= bus.pair_idx + PAIR_W'(1);
        if (b_last) begin
          cls_a <= cls_a + CLS_W'(1);
          cls_b <= cls_a + CLS_W'(2);
        end else begin
          cls_b <= cls_b + CLS_W'(1);
        end
      end

      // Strict '>' keeps the lowest index on ties.
      if (state == DECIDE) begin
        k <= k + CLS_W'(1);
        if (k_better) best <= k;
        if (k_last) bus.winner <= k_better ? k : best;
      end

`ifdef SVM_SCHED_WATCHDOG_EN
      if (state == LAUNCH)    wdog <= '0;
      else if (state == WAIT) wdog <= wdog + TMO_W'(1);
      if (wait_abort) begin
        bus.error  <= 1'b1;
        bus.winner <= '0;
      end
`endif
    end
  end
endmodule

// File: doc/svm_ovo_scheduler.md
Name: svm_ovo_scheduler

Overview:
- Sequences one shared sequential binary SVM datapath through every one-vs-one class pair of an N-class classifier.
- For each pair: emits a pair index that addresses the external weight/bias ROM, launches the SVM and waits for its result.
- Tallies one vote per pair, then runs a sequential argmax over the vote counters.
- Sits between the feature input register and the binary SVM/ROM pair; replaces fixed-class pickers for N > 3.

Parameters:
- N_CLASSES, 4, number of classes (>= 2); P = N_CLASSES*(N_CLASSES-1)/2 pairs.
- inputWidth, 4, bits per feature.
- N_features, 21, feature count.
- TIMEOUT, 64, max WAIT cycles per pair (used only with watchdog).
- Derived: CLS_W = max(1, clog2(N_CLASSES)); PAIR_W = max(1, clog2(P)); VOTE_W = clog2(N_CLASSES).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request classification; sampled only in IDLE.
- feat_in  in  inputWidth*N_features  feature vector, captured on accepted start.
- feat_out  out  inputWidth*N_features  latched features to the SVM, stable for the whole job.
- pair_idx  out  PAIR_W  current pair; drives the weight/bias ROM address.
- svm_start  out  1  one-cycle launch pulse to the SVM.
- svm_ready  in  1  SVM result-valid pulse.
- svm_class  in  1  1 = first class of pair wins, 0 = second.
- busy  out  1  high from LAUNCH through DECIDE.
- done  out  1  one-cycle pulse in DONE.
- winner  out  CLS_W  result; held until the next accepted start.
- error  out  1  watchdog abort flag (constant 0 without the feature).

Behaviour:
- Reset: state IDLE; all outputs 0; votes, feat_out, pair_idx, cls_a, cls_b cleared. Reset mid-job aborts immediately; no done pulse.
- Pair order: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1). cls_a and cls_b are counters; pair_idx increments 0..P-1 in step.
- IDLE: on start=1, latch feat_in, clear votes, clear error, set pair 0 (cls_a=0, cls_b=1), go to LAUNCH. While not in IDLE, start is ignored.
- LAUNCH (1 cycle): svm_start=1; go to WAIT. pair_idx is already stable in this cycle.
- WAIT: svm_ready sampled only here; on svm_ready, register svm_class and go to TALLY. svm_ready in any other state is ignored.
- TALLY (1 cycle): increment votes[cls_a] if the registered class is 1, else votes[cls_b]. If the last pair is done, go to DECIDE (k=0, best=0); else advance the pair and go to LAUNCH.
- Pair advance: cls_b++; if cls_b wraps past N-1, then cls_a++ and cls_b = cls_a+1.
- DECIDE (N_CLASSES cycles): scan k = 0..N-1. Replace best only when votes[k] > votes[best] (strict), so ties resolve to the lowest index. After k = N-1, load winner and go to DONE.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- Vote counters saturate-free: the maximum value is N-1, which fits VOTE_W.
- Latency with svm_ready on the first WAIT cycle: start seen in cycle 0; done in cycle 1 + 3P + N_CLASSES.

Optional Feature:
- Macro: SVM_SCHED_WATCHDOG_EN.
- Enabled: a WAIT-cycle counter is cleared on entry to WAIT. If it reaches TIMEOUT without svm_ready, go straight to DONE with error=1 and winner=0. error holds until the next accepted start.
- Disabled: no counter; WAIT lasts indefinitely; error is tied to 0.

Test Plan:
- N=4, svm_ready one cycle after each svm_start, svm_class all 1 -> votes 3,2,1,0; winner=0; done in cycle 23; six svm_start pulses with pair_idx 0..5 in order.
- N=4, svm_class all 0 -> votes 0,1,2,3; winner=3.
- N=4, svm_class 1,0,0,1,1,0 -> votes 1,2,1,2; tie resolves to winner=1.
- start pulsed during WAIT of pair 2, plus a spurious svm_ready during TALLY -> no restart, no extra vote; result unchanged vs. baseline.
- rst asserted in WAIT of pair 3 -> all outputs 0 immediately, no done. A following start runs a full 6-pair job from pair 0.
- With SVM_SCHED_WATCHDOG_EN and TIMEOUT=64, svm_ready withheld at pair 1 -> done after 64 WAIT cycles, error=1, winner=0. Next start clears error.
